// File: rtl/alu_issue_if.sv
// alu_issue_if -- decode-to-ALU handshake bundle.
//
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid && ready are both high. A valid source holds its payload
// unchanged until that edge. inReady/outReady may change freely while the
// matching valid is low.
//
// Input side : inValid/inReady, opcode, funct3, funct7b5, rs1Data, rs2Data,
//              imm, pc
// Output side: outValid/outReady, aluCode, aluIn1, aluIn2, illegal
//
// master = decode/downstream driver (testbench), slave = alu_issue.
interface alu_issue_if;
  logic        inValid;
  logic        inReady;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] imm;
  logic [31:0] pc;
  logic        outValid;
  logic        outReady;
  logic [3:0]  aluCode;
  logic [31:0] aluIn1;
  logic [31:0] aluIn2;
  logic        illegal;

  modport master (
    output inValid, opcode, funct3, funct7b5, rs1Data, rs2Data, imm, pc,
    output outReady,
    input  inReady, outValid, aluCode, aluIn1, aluIn2, illegal
  );

  modport slave (
    input  inValid, opcode, funct3, funct7b5, rs1Data, rs2Data, imm, pc,
    input  outReady,
    output inReady, outValid, aluCode, aluIn1, aluIn2, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue -- RV32I ALU operand issue stage with a two-entry skid buffer.
//
// Decodes an offered instruction combinationally into an ALU operation code
// and two operands, then holds the bundle in a main register (the visible
// output) plus one skid register so upstream sees a registered ready.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   flush     synchronous discard of held and incoming entries
//   bus       alu_issue_if.slave (input and output handshakes)
//   state_dbg current FSM state (EMPTY=0, ONE=1, FULL=2)
module alu_issue (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  alu_issue_if.slave   bus,
  output logic [1:0]   state_dbg
);

  localparam logic [3:0] CODE_ADD  = 4'b0000;
  localparam logic [3:0] CODE_SUB  = 4'b1000;
  localparam logic [3:0] CODE_SLL  = 4'b0001;
  localparam logic [3:0] CODE_SLT  = 4'b0010;
  localparam logic [3:0] CODE_SLTU = 4'b1010;
  localparam logic [3:0] CODE_XOR  = 4'b0100;
  localparam logic [3:0] CODE_OR   = 4'b0110;
  localparam logic [3:0] CODE_AND  = 4'b0111;
  localparam logic [3:0] CODE_SRL  = 4'b0101;
  localparam logic [3:0] CODE_SRA  = 4'b1101;
  localparam logic [3:0] CODE_NOP  = 4'b1111;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ill;
  } bundle_t;

  state_t  state, state_n;
  logic    in_ready_q;
  bundle_t main_q, skid_q, dec;
  logic    accept, drain;
  logic    load_main, main_from_skid, load_skid;
  logic    is_alt;

  // Combinational decode of the offered instruction.
  always_comb begin
    dec    = '{code: CODE_NOP, in1: 32'd0, in2: 32'd0, ill: 1'b0};
    is_alt = 1'b0;
    case (bus.opcode)
      7'b0110011, 7'b0010011: begin
        // funct7b5 alters ADD->SUB only for register-register ops, but
        // alters SRL->SRA for both forms.
        is_alt = bus.funct7b5 &&
                 ((bus.funct3 == 3'b101) ||
                  (bus.funct3 == 3'b000 && bus.opcode == 7'b0110011));
        case (bus.funct3)
          3'b000:  dec.code = is_alt ? CODE_SUB : CODE_ADD;
          3'b001:  dec.code = CODE_SLL;
          3'b010:  dec.code = CODE_SLT;
          3'b011:  dec.code = CODE_SLTU;
          3'b100:  dec.code = CODE_XOR;
          3'b101:  dec.code = is_alt ? CODE_SRA : CODE_SRL;
          3'b110:  dec.code = CODE_OR;
          default: dec.code = CODE_AND;
        endcase
        dec.in1 = bus.rs1Data;
        dec.in2 = (bus.opcode == 7'b0110011) ? bus.rs2Data : bus.imm;
      end
      7'b0110111: begin
        dec.code = CODE_ADD;
        dec.in2  = bus.imm;
      end
      7'b0010111: begin
        dec.code = CODE_ADD;
        dec.in1  = bus.pc;
        dec.in2  = bus.imm;
      end
      default: dec.ill = 1'b1;
    endcase
  end

  assign accept = bus.inValid && in_ready_q;
  assign drain  = (state != EMPTY) && bus.outReady;

  // Next-state and register-load controls.
  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_n   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          // Upstream is held off here, so only a drain can happen.
          if (drain) begin
            state_n        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '{code: CODE_NOP, in1: 32'd0, in2: 32'd0, ill: 1'b0};
      skid_q     <= '{code: CODE_NOP, in1: 32'd0, in2: 32'd0, ill: 1'b0};
    end else begin
      state      <= state_n;
      // Ready is registered: it is high for the next cycle unless the
      // skid slot will be occupied.
      in_ready_q <= (state_n != FULL);
      if (load_main) main_q <= main_from_skid ? skid_q : dec;
      if (load_skid) skid_q <= dec;
    end
  end

  // Outputs show the reset bundle whenever nothing is held, so stale main
  // contents never leak after a drain or flush.
  assign bus.inReady  = in_ready_q;
  assign bus.outValid = (state != EMPTY);
  assign bus.aluCode  = bus.outValid ? main_q.code : CODE_NOP;
  assign bus.aluIn1   = bus.outValid ? main_q.in1  : 32'd0;
  assign bus.aluIn2   = bus.outValid ? main_q.in2  : 32'd0;
  assign bus.illegal  = bus.outValid && main_q.ill;
  assign state_dbg    = state;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: none; data width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 flush  input  1  synchronous discard of all held and incoming entries.
REQ-005 inValid  input  1  upstream decode offers an instruction.
REQ-006 inReady  output  1  block can accept; transfer when inValid && inReady.
REQ-007 opcode  input  7  RV32I major opcode.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7b5  input  1  instruction bit 30.
REQ-010 rs1Data, rs2Data  input  32 each  register operands.
REQ-011 imm  input  32  sign-extended immediate (LUI/AUIPC: already shifted).
REQ-012 pc  input  32  instruction address.
REQ-013 outValid  output  1  ALU operand bundle valid.
REQ-014 outReady  input  1  downstream accepts; transfer when outValid && outReady.
REQ-015 aluCode  output  4  ALU operation code.
REQ-016 aluIn1, aluIn2  output  32 each  ALU operands.
REQ-017 illegal  output  1  bundle came from an unsupported opcode.

Function
REQ-018 Code values SHALL be ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 1010, XOR 0100, OR 0110, AND 0111, SRL 0101, SRA 1101, NOP 1111.
REQ-019 opcode 0110011 (R-type): funct3 000->ADD (SUB if funct7b5), 001->SLL, 010->SLT, 011->SLTU, 100->XOR, 101->SRL (SRA if funct7b5), 110->OR, 111->AND; aluIn1=rs1Data, aluIn2=rs2Data.
REQ-020 opcode 0010011 (I-type): same table except funct3 000 always ADD; aluIn1=rs1Data, aluIn2=imm.
REQ-021 I-type shifts SHALL pass imm unchanged; funct7b5 selects SRA only for funct3 101.
REQ-022 opcode 0110111 (LUI): ADD, aluIn1=0, aluIn2=imm.
REQ-023 opcode 0010111 (AUIPC): ADD, aluIn1=pc, aluIn2=imm.
REQ-024 Any other opcode SHALL be accepted and issued as NOP, operands 0, illegal=1; illegal=0 otherwise.
REQ-025 Decode is combinational at input; bundle registered; latency 1 cycle from acceptance to outValid when empty.
REQ-026 Storage: main register plus one skid register (2 entries); strict in-order issue.
REQ-027 inReady SHALL be a registered signal, high exactly when skid entry empty.
REQ-028 States: EMPTY (no entries), ONE (main valid), FULL (main+skid valid).
REQ-029 EMPTY: accept -> ONE.
REQ-030 ONE: accept and drain -> ONE (main loaded with new); accept no drain -> FULL (new into skid); drain no accept -> EMPTY.
REQ-031 FULL: inReady=0; drain -> ONE with skid moved to main next cycle.
REQ-032 outValid=1 in ONE/FULL; output bundle SHALL be stable while outValid && !outReady.
REQ-033 flush SHALL empty both entries next cycle (EMPTY, inReady=1); input offered in flush cycle is discarded; flush wins over all simultaneous accept/drain.
REQ-034 outReady while EMPTY has no effect.

Reset
REQ-035 On reset: state EMPTY, outValid=0, inReady=1, aluCode=NOP, aluIn1=aluIn2=0, illegal=0.
REQ-036 Reset mid-transfer SHALL drop all held entries; no bundle issued after deassertion until new acceptance.

Verification
REQ-037 R-type SUB: opcode 0110011, funct3 000, funct7b5 1, rs1 10, rs2 3, outReady=1 -> next cycle outValid=1, aluCode 1000, aluIn1 10, aluIn2 3.
REQ-038 I-type SLTIU: opcode 0010011, funct3 011, rs1 5, imm 0xFFFFFFFF -> aluCode 1010, aluIn2 0xFFFFFFFF; SRAI funct7b5 1 -> aluCode 1101.
REQ-039 AUIPC pc 0x1000, imm 0x2000 -> ADD, aluIn1 0x1000, aluIn2 0x2000; opcode 0000011 -> NOP, operands 0, illegal 1.
REQ-040 Backpressure: outReady=0, send A,B,C back-to-back -> A,B accepted, inReady 0 on C; raise outReady -> A,B,C issued in order, no loss or duplicate.
REQ-041 Flush in FULL with new input offered -> next cycle outValid 0, inReady 1; offered input never issued.
REQ-042 Assert reset with two entries held -> outputs immediately at reset values; after release outValid stays 0 until new transfer.
